// File: rtl/hms_clock_core_if.sv
// Control pulses and time/display outputs exchanged between the switch
// front end, the timekeeping core and the display back end.
interface hms_clock_core_if;
   logic       i_mode_pulse;
   logic       i_pos_pulse;
   logic       i_inc_pulse;
   logic       i_fmt_12h;
   logic [5:0] o_sec;
   logic [5:0] o_min;
   logic [4:0] o_hour;
   logic       o_pm;
   logic       o_mode;
   logic [1:0] o_position;
   logic [2:0] o_blink_mask;
   logic       o_max_hit_sec;
   logic       o_max_hit_min;
   logic       o_max_hit_hour;

   modport master (
      output i_mode_pulse, i_pos_pulse, i_inc_pulse, i_fmt_12h,
      input  o_sec, o_min, o_hour, o_pm, o_mode, o_position, o_blink_mask,
      input  o_max_hit_sec, o_max_hit_min, o_max_hit_hour
   );

   modport slave (
      input  i_mode_pulse, i_pos_pulse, i_inc_pulse, i_fmt_12h,
      output o_sec, o_min, o_hour, o_pm, o_mode, o_position, o_blink_mask,
      output o_max_hit_sec, o_max_hit_min, o_max_hit_hour
   );
endinterface

// File: rtl/hms_clock_core.sv
// Hour:minute:second timekeeping core with setup mode; every counter runs
// on the single clock, advanced by a prescaler-derived tick enable.
module hms_clock_core #(
   parameter int unsigned TICK_NUM = 50000000
) (
   input logic            clk,
   input logic            rst,
   hms_clock_core_if.slave bus
);

   typedef enum logic {
      MODE_CLOCK = 1'b0,
      MODE_SETUP = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      POS_SEC  = 2'd0,
      POS_MIN  = 2'd1,
      POS_HOUR = 2'd2
   } pos_t;

   localparam logic [31:0] TickLast   = 32'(TICK_NUM - 1);
   localparam logic [31:0] BlinkStart = 32'(TICK_NUM / 2);

   logic [31:0] pcnt_q, pcnt_d;
   logic [5:0]  sec_q, sec_d;
   logic [5:0]  min_q, min_d;
   logic [4:0]  hour_q, hour_d;
   mode_t       mode_q, mode_d;
   pos_t        pos_q, pos_d;
   logic        hitSec_q, hitSec_d;
   logic        hitMin_q, hitMin_d;
   logic        hitHour_q, hitHour_d;
   logic        fmt12h_q;
   logic        tick;
   logic [4:0]  hourDisp;
   logic [2:0]  blinkMask;

   // The mode in force before this edge decides whether a tick counts, so a
   // tick coinciding with leaving CLOCK still advances time.
   always_comb begin
      tick      = (pcnt_q == TickLast);
      pcnt_d    = tick ? 32'd0 : pcnt_q + 32'd1;
      sec_d     = sec_q;
      min_d     = min_q;
      hour_d    = hour_q;
      mode_d    = mode_q;
      pos_d     = pos_q;
      hitSec_d  = 1'b0;
      hitMin_d  = 1'b0;
      hitHour_d = 1'b0;

      if (mode_q == MODE_CLOCK) begin
         if (tick) begin
            if (sec_q == 6'd59) begin
               sec_d    = 6'd0;
               hitSec_d = 1'b1;
               if (min_q == 6'd59) begin
                  min_d    = 6'd0;
                  hitMin_d = 1'b1;
                  if (hour_q == 5'd23) begin
                     hour_d    = 5'd0;
                     hitHour_d = 1'b1;
                  end else begin
                     hour_d = hour_q + 5'd1;
                  end
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end
         if (bus.i_mode_pulse) begin
            mode_d = MODE_SETUP;
         end
      end else begin
         if (bus.i_mode_pulse) begin
            mode_d = MODE_CLOCK;
            pcnt_d = 32'd0;
         end else if (bus.i_inc_pulse) begin
            // Setup wraps stay local: no carry and no max-hit pulse.
            case (pos_q)
               POS_SEC:  sec_d  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
               POS_MIN:  min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
               default:  hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            endcase
         end
      end

      if (bus.i_pos_pulse) begin
         case (pos_q)
            POS_SEC: pos_d = POS_MIN;
            POS_MIN: pos_d = POS_HOUR;
            default: pos_d = POS_SEC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q    <= 32'd0;
         sec_q     <= 6'd0;
         min_q     <= 6'd0;
         hour_q    <= 5'd0;
         mode_q    <= MODE_CLOCK;
         pos_q     <= POS_SEC;
         hitSec_q  <= 1'b0;
         hitMin_q  <= 1'b0;
         hitHour_q <= 1'b0;
      end else begin
         pcnt_q    <= pcnt_d;
         sec_q     <= sec_d;
         min_q     <= min_d;
         hour_q    <= hour_d;
         mode_q    <= mode_d;
         pos_q     <= pos_d;
         hitSec_q  <= hitSec_d;
         hitMin_q  <= hitMin_d;
         hitHour_q <= hitHour_d;
      end
   end

   // The format select is registered so the display hour depends on flops only.
   always_ff @(posedge clk) begin
      fmt12h_q <= bus.i_fmt_12h;
   end

   always_comb begin
      hourDisp = hour_q;
      if (fmt12h_q) begin
         if (hour_q == 5'd0) begin
            hourDisp = 5'd12;
         end else if (hour_q > 5'd12) begin
            hourDisp = hour_q - 5'd12;
         end
      end
   end

   // Blank the edited field during the second half of each second.
   always_comb begin
      blinkMask = 3'b000;
      if (mode_q == MODE_SETUP && pcnt_q >= BlinkStart) begin
         case (pos_q)
            POS_SEC:  blinkMask = 3'b001;
            POS_MIN:  blinkMask = 3'b010;
            default:  blinkMask = 3'b100;
         endcase
      end
   end

   assign bus.o_sec          = sec_q;
   assign bus.o_min          = min_q;
   assign bus.o_hour         = hourDisp;
   assign bus.o_pm           = (hour_q >= 5'd12);
   assign bus.o_mode         = mode_q;
   assign bus.o_position     = pos_q;
   assign bus.o_blink_mask   = blinkMask;
   assign bus.o_max_hit_sec  = hitSec_q;
   assign bus.o_max_hit_min  = hitMin_q;
   assign bus.o_max_hit_hour = hitHour_q;

endmodule

// File: tb/tb_hms_clock_core.sv
// Directed self-checking bench for hms_clock_core with a ten-cycle second.
module tb_hms_clock_core;

   logic clk;
   logic rst;
   int   totalCount;
   int   passCount;
   int   pulseCount;

   hms_clock_core_if bus ();

   hms_clock_core #(
      .TICK_NUM (10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
   endtask

   // Drive one cycle of pulses starting at a falling edge.
   task automatic applyStimulus(input logic modeP, input logic posP, input logic incP);
      bus.i_mode_pulse = modeP;
      bus.i_pos_pulse  = posP;
      bus.i_inc_pulse  = incP;
      @(negedge clk);
      bus.i_mode_pulse = 1'b0;
      bus.i_pos_pulse  = 1'b0;
      bus.i_inc_pulse  = 1'b0;
   endtask

   task automatic holdInc(input int n);
      bus.i_inc_pulse = 1'b1;
      repeat (n) @(negedge clk);
      bus.i_inc_pulse = 1'b0;
   endtask

   task automatic runCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkTime(input string tag, input int s, input int m, input int h);
      checkOutput({tag, ".sec"}, 32'(bus.o_sec), 32'(s));
      checkOutput({tag, ".min"}, 32'(bus.o_min), 32'(m));
      checkOutput({tag, ".hour"}, 32'(bus.o_hour), 32'(h));
   endtask

   task automatic checkHits(input string tag, input logic hs, input logic hm, input logic hh);
      checkOutput({tag, ".hitSec"}, 32'(bus.o_max_hit_sec), 32'(hs));
      checkOutput({tag, ".hitMin"}, 32'(bus.o_max_hit_min), 32'(hm));
      checkOutput({tag, ".hitHour"}, 32'(bus.o_max_hit_hour), 32'(hh));
   endtask

   initial begin
      totalCount       = 0;
      passCount        = 0;
      pulseCount       = 0;
      rst              = 1'b1;
      bus.i_mode_pulse = 1'b0;
      bus.i_pos_pulse  = 1'b0;
      bus.i_inc_pulse  = 1'b0;
      bus.i_fmt_12h    = 1'b0;

      // Reset state, both display formats while reset is held.
      runCycles(2);
      checkTime("reset", 0, 0, 0);
      checkOutput("reset.pm", 32'(bus.o_pm), 0);
      checkOutput("reset.mode", 32'(bus.o_mode), 0);
      checkOutput("reset.pos", 32'(bus.o_position), 0);
      checkOutput("reset.mask", 32'(bus.o_blink_mask), 0);
      checkHits("reset", 0, 0, 0);
      bus.i_fmt_12h = 1'b1;
      runCycles(1);
      checkOutput("reset.hour12", 32'(bus.o_hour), 12);
      bus.i_fmt_12h = 1'b0;
      runCycles(1);
      rst = 1'b0;

      // One minute of free running.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (bus.o_max_hit_sec) pulseCount++;
      end
      checkOutput("run600.secPulses", 32'(pulseCount), 1);
      checkOutput("run600.hitNow", 32'(bus.o_max_hit_sec), 1);
      checkTime("run600", 0, 1, 0);
      runCycles(1);
      checkHits("run600.after", 0, 0, 0);

      // Preset 23:59:58 and roll over midnight.
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("preset.mode", 32'(bus.o_mode), 1);
      holdInc(58);
      applyStimulus(1'b0, 1'b1, 1'b0);
      holdInc(58);
      applyStimulus(1'b0, 1'b1, 1'b0);
      holdInc(23);
      checkTime("preset", 58, 59, 23);
      checkOutput("preset.pm", 32'(bus.o_pm), 1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("preset.exitMode", 32'(bus.o_mode), 0);
      runCycles(19);
      checkTime("midnight.before", 59, 59, 23);
      checkHits("midnight.before", 0, 0, 0);
      runCycles(1);
      checkTime("midnight", 0, 0, 0);
      checkHits("midnight", 1, 1, 1);
      runCycles(1);
      checkHits("midnight.after", 0, 0, 0);

      // Minute wrap inside setup, then pos and inc together.
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("setupWrap.pos", 32'(bus.o_position), 1);
      holdInc(59);
      checkOutput("setupWrap.min59", 32'(bus.o_min), 59);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkTime("setupWrap", 0, 0, 0);
      checkHits("setupWrap", 0, 0, 0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("posInc.min", 32'(bus.o_min), 1);
      checkOutput("posInc.pos", 32'(bus.o_position), 2);
      checkOutput("posInc.hour", 32'(bus.o_hour), 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("modeInc.mode", 32'(bus.o_mode), 0);
      checkOutput("modeInc.hour", 32'(bus.o_hour), 0);
      applyStimulus(1'b1, 1'b0, 1'b0);

      // 12-hour display conversion.
      bus.i_fmt_12h = 1'b1;
      runCycles(1);
      checkOutput("fmt12.h0", 32'(bus.o_hour), 12);
      checkOutput("fmt12.pm0", 32'(bus.o_pm), 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("fmt12.h1", 32'(bus.o_hour), 1);
      checkOutput("fmt12.pm1", 32'(bus.o_pm), 0);
      holdInc(11);
      checkOutput("fmt12.h12", 32'(bus.o_hour), 12);
      checkOutput("fmt12.pm12", 32'(bus.o_pm), 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("fmt12.h13", 32'(bus.o_hour), 1);
      checkOutput("fmt12.pm13", 32'(bus.o_pm), 1);
      holdInc(10);
      checkOutput("fmt12.h23", 32'(bus.o_hour), 11);
      checkOutput("fmt12.pm23", 32'(bus.o_pm), 1);
      bus.i_fmt_12h = 1'b0;
      runCycles(1);
      checkOutput("fmt24.h23", 32'(bus.o_hour), 23);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkTime("hourWrap", 0, 1, 0);
      checkHits("hourWrap", 0, 0, 0);

      // Blink mask over one prescaler period, then exit timing.
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         checkOutput($sformatf("blink.p%0d", (1 + k) % 10), 32'(bus.o_blink_mask),
                     (((1 + k) % 10) >= 5) ? 32'd4 : 32'd0);
         @(negedge clk);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("exit.mode", 32'(bus.o_mode), 0);
      checkOutput("exit.mask", 32'(bus.o_blink_mask), 0);
      runCycles(9);
      checkOutput("exit.maskLate", 32'(bus.o_blink_mask), 0);
      checkOutput("exit.sec9", 32'(bus.o_sec), 0);
      runCycles(1);
      checkOutput("exit.sec10", 32'(bus.o_sec), 1);

      // Reset in the middle of setup at 12:34:56.
      applyStimulus(1'b1, 1'b0, 1'b0);
      holdInc(12);
      applyStimulus(1'b0, 1'b1, 1'b0);
      holdInc(55);
      applyStimulus(1'b0, 1'b1, 1'b0);
      holdInc(33);
      checkTime("midReset.before", 56, 34, 12);
      checkOutput("midReset.beforeMode", 32'(bus.o_mode), 1);
      rst = 1'b1;
      runCycles(1);
      rst = 1'b0;
      checkTime("midReset", 0, 0, 0);
      checkOutput("midReset.mode", 32'(bus.o_mode), 0);
      checkOutput("midReset.pos", 32'(bus.o_position), 0);
      checkOutput("midReset.mask", 32'(bus.o_blink_mask), 0);
      checkOutput("midReset.pm", 32'(bus.o_pm), 0);
      checkHits("midReset", 0, 0, 0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
